// File: rtl/negate_arbiter.sv
// negate_arbiter: two requesters share one two's-complement negate unit.
// Round-robin grant, registered result with valid/ready, flags -MIN overflow.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   req0/a0, req1/a1   requests and operands (held until granted)
//   gnt0, gnt1         one-cycle capture pulses
//   out_valid/out_ready result handshake
//   out_id             owner of out_data
//   out_data, out_ovf  negated operand and "operand was most-negative" flag
//   busy               unit is not idle
module negate_arbiter #(
  parameter int WIDTH      = 4,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_d;
  logic [WIDTH-1:0] op_reg;
  logic [WIDTH-1:0] op_d;
  logic             id_reg;
  logic             id_d;
  logic             last;
  logic             last_d;
  logic             gnt0_d;
  logic             gnt1_d;
  logic             ov_d;
  logic [WIDTH-1:0] od_d;
  logic             oid_d;
  logic             oovf_d;
  logic [WIDTH-1:0] neg;
  logic             sel0;
  logic             sel1;

  assign neg  = ~op_reg + ONE;
  assign busy = (state != IDLE);

  // On a tie the requester that was not served last wins;
  // sel0 and sel1 are mutually exclusive by construction.
  assign sel0 = req0 & (~req1 | last);
  assign sel1 = req1 & (~req0 | ~last);

  always_comb begin
    state_d = state;
    op_d    = op_reg;
    id_d    = id_reg;
    last_d  = last;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    ov_d    = out_valid;
    od_d    = out_data;
    oid_d   = out_id;
    oovf_d  = out_ovf;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          sel0: begin
            op_d    = a0;
            id_d    = 1'b0;
            last_d  = 1'b0;
            gnt0_d  = 1'b1;
            state_d = CALC;
          end
          sel1: begin
            op_d    = a1;
            id_d    = 1'b1;
            last_d  = 1'b1;
            gnt1_d  = 1'b1;
            state_d = CALC;
          end
          default: ;
        endcase
      end
      CALC: begin
        od_d    = neg;
        oovf_d  = (op_reg == MINV);
        oid_d   = id_reg;
        ov_d    = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_reg    <= '0;
      id_reg    <= 1'b0;
      last      <= ~PRIO_RESET;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      state     <= state_d;
      op_reg    <= op_d;
      id_reg    <= id_d;
      last      <= last_d;
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      out_valid <= ov_d;
      out_data  <= od_d;
      out_id    <= oid_d;
      out_ovf   <= oovf_d;
    end
  end

endmodule

// File: tb/tb_negate_arbiter.sv
// tb_negate_arbiter: vector table, hand sequences and
// random traffic against a transaction-level model.
module tb_negate_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic [3:0] a0 = '0;
  logic       req1 = 1'b0;
  logic [3:0] a1 = '0;
  logic       gnt0;
  logic       gnt1;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_id;
  logic [3:0] out_data;
  logic       out_ovf;
  logic       busy;

  int checks = 0;
  int failures = 0;

  negate_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .a0        (a0),
    .req1      (req1),
    .a1        (a1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] data;
    logic       ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0;
    req1 = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic single_op(input vec_t v);
    if (v.id) begin
      req1 = 1'b1;
      a1 = v.a;
    end else begin
      req0 = 1'b1;
      a0 = v.a;
    end
    tick();
    chk("vec_gnt0", gnt0, !v.id);
    chk("vec_gnt1", gnt1, v.id);
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    chk("vec_valid", out_valid, 1);
    chk("vec_data", out_data, v.data);
    chk("vec_ovf", out_ovf, v.ovf);
    chk("vec_id", out_id, v.id);
    tick();
    chk("vec_done", {out_valid, busy}, 0);
  endtask

  // random-phase model state
  logic [3:0] qa[$];
  logic       qid[$];
  int         last_g;
  bit         acc;
  int         w0;
  int         w1;
  bit         gid;
  int         ref_d;

  initial begin
    vecs[0] = '{1'b0, 4'h3, 4'hD, 1'b0};
    vecs[1] = '{1'b1, 4'h8, 4'h8, 1'b1};
    vecs[2] = '{1'b0, 4'h0, 4'h0, 1'b0};
    vecs[3] = '{1'b1, 4'h1, 4'hF, 1'b0};
    vecs[4] = '{1'b0, 4'h7, 4'h9, 1'b0};
    vecs[5] = '{1'b1, 4'hF, 4'h1, 1'b0};
    vecs[6] = '{1'b0, 4'h9, 4'h7, 1'b0};
    vecs[7] = '{1'b1, 4'hC, 4'h4, 1'b0};
    vecs[8] = '{1'b0, 4'h8, 4'h8, 1'b1};
    vecs[9] = '{1'b1, 4'h2, 4'hE, 1'b0};

    // reset values, checked while reset is held
    rst_n = 1'b0;
    tick();
    chk("rst_outs",
        {gnt0, gnt1, out_valid, out_id, out_ovf, busy},
        0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) single_op(vecs[i]);

    // both held: alternate 0,1,0,1 three cycles apart
    do_reset();
    begin
      int ng = 0;
      int lastc = -1;
      req0 = 1'b1;
      a0 = 4'h1;
      req1 = 1'b1;
      a1 = 4'h2;
      for (int c = 0; c < 16 && ng < 4; c++) begin
        tick();
        if (out_valid)
          chk("alt_data", out_data,
              out_id ? 4'hE : 4'hF);
        if (gnt0 || gnt1) begin
          chk("alt_id", gnt1, ng % 2);
          if (lastc >= 0) chk("alt_gap", c - lastc, 3);
          lastc = c;
          ng++;
        end
      end
      chk("alt_count", ng, 4);
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (4) tick();
    end

    // backpressure: RESP held, req1 ignored until released
    do_reset();
    req0 = 1'b1;
    a0 = 4'h5;
    out_ready = 1'b0;
    tick();
    chk("bp_gnt0", gnt0, 1);
    req0 = 1'b0;
    req1 = 1'b1;
    a1 = 4'h6;
    tick();
    chk("bp_valid", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold",
          {out_valid, out_data, out_id, out_ovf, busy, gnt1},
          {1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release", {out_valid, busy, gnt1}, 0);
    tick();
    chk("bp_gnt1", gnt1, 1);
    req1 = 1'b0;
    tick();
    chk("bp_res",
        {out_valid, out_data, out_id},
        {1'b1, 4'hA, 1'b1});
    tick();

    // async reset during RESP; then tie goes to requester 0
    req0 = 1'b1;
    a0 = 4'h3;
    out_ready = 1'b0;
    tick();
    req0 = 1'b0;
    tick();
    chk("ar_resp", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async",
        {out_valid, busy, out_data},
        0);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    req0 = 1'b1;
    a0 = 4'h4;
    req1 = 1'b1;
    a1 = 4'h4;
    tick();
    chk("ar_tie", {gnt0, gnt1}, 2'b10);
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (3) tick();

    // random traffic vs. transaction model
    do_reset();
    last_g = 1;
    acc = 1'b0;
    w0 = 0;
    w1 = 0;
    for (int c = 0; c < 600; c++) begin
      bit g0;
      bit g1;
      tick();
      if (acc) begin
        void'(qa.pop_front());
        void'(qid.pop_front());
      end
      g0 = gnt0;
      g1 = gnt1;
      if (g0 && g1) chk("rnd_excl", 1, 0);
      if (g0 || g1) begin
        gid = g1;
        chk("rnd_gnt_req", gid ? req1 : req0, 1);
        if (req0 && req1) chk("rnd_rr", gid, last_g == 0);
        last_g = gid;
        qa.push_back(gid ? a1 : a0);
        qid.push_back(gid);
        if (gid) begin
          req1 = 1'b0;
          w1 = 0;
        end else begin
          req0 = 1'b0;
          w0 = 0;
        end
      end
      if (out_valid) begin
        if (qa.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          ref_d = (16 - int'(qa[0])) % 16;
          chk("rnd_data", out_data, ref_d);
          chk("rnd_ovf", out_ovf, qa[0] == 4'h8);
          chk("rnd_id", out_id, qid[0]);
        end
      end
      if (req0) w0++;
      if (req1) w1++;
      if (w0 > 30 || w1 > 30) begin
        chk("rnd_starve", 1, 0);
        w0 = 0;
        w1 = 0;
      end
      if (c < 560) begin
        if (!req0 && !g0 && $urandom_range(0, 2) == 0) begin
          req0 = 1'b1;
          a0 = 4'($urandom);
        end
        if (!req1 && !g1 && $urandom_range(0, 2) == 0) begin
          req1 = 1'b1;
          a1 = 4'($urandom);
        end
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      acc = out_valid && out_ready;
    end
    chk("rnd_drain", qa.size(), 0);
    chk("rnd_idle", {busy, out_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
